// File: rtl/cmd_pkg.sv
// cmd_pkg: command/error codes, response byte defaults and state encodings shared by the executor.
// CMD_ECHO_EN selects the build that prefixes every response with the command byte.
package cmd_pkg;
    localparam logic [7:0] CMD_READ       = 8'h01;
    localparam logic [7:0] CMD_WRITE      = 8'h02;
    localparam logic [2:0] ERR_NONE       = 3'b000;
    localparam logic [2:0] ERR_CMD        = 3'b001;
    localparam logic [2:0] ERR_ADDR0      = 3'b010;
    localparam logic [2:0] ERR_ADDR1      = 3'b011;
    localparam logic [2:0] ERR_DATA       = 3'b100;
    localparam logic [7:0] ACK_BYTE_DEF   = 8'hAA;
    localparam logic [7:0] ERR_PREFIX_DEF = 8'hE0;
`ifdef CMD_ECHO_EN
    localparam int ECHO_N = 1;
`else
    localparam int ECHO_N = 0;
`endif
    typedef enum logic [2:0] {EX_IDLE, EX_MEM_WR, EX_MEM_RD, EX_RD_WAIT, EX_RESP} exec_state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_REQ, TX_ACK, TX_DONE} tx_state_t;
endpackage

// File: rtl/resp_serializer.sv
// resp_serializer: shifts a loaded response out LSB byte first over the tx_start/tx_busy handshake.
module resp_serializer
    import cmd_pkg::*;
#(
    parameter int SR_W = 40
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            load,
    input  logic [SR_W-1:0] load_data,
    input  logic [2:0]      load_count,
    input  logic            tx_busy,
    output logic [7:0]      tx_byte,
    output logic            tx_start,
    output logic            done
);
    tx_state_t state, state_nx;
    logic [SR_W-1:0] sr;
    logic [2:0] cnt;
    logic [3:0] wait_cnt;
    logic ack_timeout;
    // A transmitter that never raises busy is taken to have accepted the byte after 16 cycles.
    assign ack_timeout = wait_cnt == 4'd15;
    assign tx_byte = sr[7:0];
    always_ff @(posedge clock) begin
        if (reset)
            state <= TX_IDLE;
        else
            state <= state_nx;
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            sr <= '0;
            cnt <= '0;
            wait_cnt <= '0;
        end else begin
            wait_cnt <= state == TX_ACK ? wait_cnt + 4'd1 : 4'd0;
            if (load) begin
                sr <= load_data;
                cnt <= load_count;
            end else if (state == TX_DONE && !tx_busy) begin
                sr <= sr >> 8;
                cnt <= cnt - 3'd1;
            end
        end
    end
    always_comb begin
        state_nx = state;
        case (state)
            TX_IDLE: state_nx = load ? TX_REQ : TX_IDLE;
            TX_REQ:  state_nx = tx_busy ? TX_REQ : TX_ACK;
            TX_ACK:  state_nx = (tx_busy || ack_timeout) ? TX_DONE : TX_ACK;
            TX_DONE: state_nx = tx_busy ? TX_DONE : (cnt == 3'd1 ? TX_IDLE : TX_REQ);
            default: state_nx = TX_IDLE;
        endcase
    end
    always_comb begin
        tx_start = state == TX_REQ && !tx_busy;
        done = state == TX_DONE && !tx_busy && cnt == 3'd1;
    end
endmodule

// File: rtl/command_executor.sv
// command_executor: runs decoded UART packets against a synchronous RAM and serialises the response.
// Define CMD_ECHO_EN to prefix every response with the packet's command byte.
module command_executor
    import cmd_pkg::*;
#(
    parameter int         ADDR_W      = 15,
    parameter int         DATA_W      = 32,
    parameter int         MEM_LATENCY = 1,
    parameter logic [7:0] ACK_BYTE    = ACK_BYTE_DEF,
    parameter logic [7:0] ERR_PREFIX  = ERR_PREFIX_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_done,
    input  logic              i_readwrite,
    input  logic [7:0]        i_command,
    input  logic [ADDR_W-1:0] i_address,
    input  logic [DATA_W-1:0] i_data,
    input  logic [2:0]        i_error,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [7:0]        tx_byte,
    output logic              tx_start,
    input  logic              tx_busy,
    output logic              o_busy,
    output logic              o_dropped
);
    localparam int SR_W = DATA_W + 8;
    exec_state_t state, state_nx;
    logic [7:0] cmd_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic [1:0] lat_q;
    logic lat_done;
    logic ld;
    logic ser_done;
    logic [7:0] cmd_src;
    logic [DATA_W-1:0] payload;
    logic [SR_W-1:0] ld_data;
    logic [2:0] ld_count;
    assign lat_done = lat_q == 2'(MEM_LATENCY - 1);
    assign mem_addr = addr_q;
    assign mem_wdata = data_q;
    always_ff @(posedge clock) begin
        if (reset)
            state <= EX_IDLE;
        else
            state <= state_nx;
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            cmd_q <= '0;
            addr_q <= '0;
            data_q <= '0;
            lat_q <= '0;
            o_dropped <= 1'b0;
        end else begin
            o_dropped <= i_done && state != EX_IDLE;
            lat_q <= state == EX_RD_WAIT ? lat_q + 2'd1 : 2'd0;
            if (state == EX_IDLE && i_done) begin
                cmd_q <= i_command;
                addr_q <= i_address;
                data_q <= i_data;
            end
        end
    end
    always_comb begin
        state_nx = state;
        case (state)
            EX_IDLE:    state_nx = !i_done ? EX_IDLE : i_error != ERR_NONE ? EX_RESP : i_readwrite ? EX_MEM_RD : EX_MEM_WR;
            EX_MEM_WR:  state_nx = EX_RESP;
            EX_MEM_RD:  state_nx = EX_RD_WAIT;
            EX_RD_WAIT: state_nx = lat_done ? EX_RESP : EX_RD_WAIT;
            EX_RESP:    state_nx = ser_done ? EX_IDLE : EX_RESP;
            default:    state_nx = EX_IDLE;
        endcase
    end
    // Error responses load straight from the decoder inputs since nothing has been latched yet.
    always_comb begin
        mem_en = state == EX_MEM_WR || state == EX_MEM_RD;
        mem_we = state == EX_MEM_WR;
        o_busy = state != EX_IDLE;
        ld = (state == EX_IDLE && i_done && i_error != ERR_NONE) || state == EX_MEM_WR || (state == EX_RD_WAIT && lat_done);
        cmd_src = state == EX_IDLE ? i_command : cmd_q;
        payload = state == EX_IDLE ? DATA_W'(ERR_PREFIX | {5'b0, i_error}) : state == EX_MEM_WR ? DATA_W'(ACK_BYTE) : mem_rdata;
        ld_count = (state == EX_RD_WAIT ? 3'd4 : 3'd1) + 3'(ECHO_N);
    end
    // Without echo the command sits above the payload and is never reached by the byte count.
`ifdef CMD_ECHO_EN
    assign ld_data = {payload, cmd_src};
`else
    assign ld_data = {cmd_src, payload};
`endif
    resp_serializer #(.SR_W(SR_W)) u_ser (
        .clock(clock),
        .reset(reset),
        .load(ld),
        .load_data(ld_data),
        .load_count(ld_count),
        .tx_busy(tx_busy),
        .tx_byte(tx_byte),
        .tx_start(tx_start),
        .done(ser_done)
    );
endmodule

// File: tb/tb_command_executor.sv
// tb_command_executor: randomized bench; expected responses come from a packet-level model and
// a RAM/transmitter model with a strict read-latency window.
`timescale 1ns/1ps
module tb_command_executor;
    localparam int LAT = 3;
    logic clock = 1'b0;
    logic reset = 1'b1;
    logic i_done = 1'b0;
    logic i_readwrite = 1'b0;
    logic [7:0] i_command = '0;
    logic [14:0] i_address = '0;
    logic [31:0] i_data = '0;
    logic [2:0] i_error = '0;
    logic mem_en, mem_we, tx_start, o_busy, o_dropped;
    logic [14:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic [7:0] tx_byte;
    logic tx_busy = 1'b0;

    command_executor #(.MEM_LATENCY(LAT)) dut (
        .clock(clock), .reset(reset), .i_done(i_done), .i_readwrite(i_readwrite),
        .i_command(i_command), .i_address(i_address), .i_data(i_data), .i_error(i_error),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .tx_byte(tx_byte), .tx_start(tx_start), .tx_busy(tx_busy),
        .o_busy(o_busy), .o_dropped(o_dropped)
    );

    initial forever #5 clock = ~clock;
    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int en_cnt, we_cnt, drop_cnt, first_start_cyc;
    int rd_delay = 0;
    int busy_wait = 0;
    int busy_len = 0;
    bit hold_busy = 0;
    logic [31:0] rd_pend, nx_rdata = '0;
    logic nx_busy = 1'b0;
    logic [14:0] last_waddr;
    logic [31:0] last_wdata;
    logic [7:0] got[$];
    logic [31:0] ram[int];
    logic [31:0] ref_mem[int];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // RAM with data valid only in the exact latency cycle, plus a transmitter with random busy timing.
    initial forever begin
        @(posedge clock);
        cyc++;
        #1;
        tx_busy = nx_busy;
        mem_rdata = nx_rdata;
        @(negedge clock);
        if (mem_en) begin
            en_cnt++;
            if (mem_we) begin
                we_cnt++;
                last_waddr = mem_addr;
                last_wdata = mem_wdata;
                ram[int'(mem_addr)] = mem_wdata;
            end else begin
                rd_delay = LAT;
                rd_pend = ram.exists(int'(mem_addr)) ? ram[int'(mem_addr)] : 32'h0;
            end
        end
        if (rd_delay > 0) begin
            rd_delay--;
            nx_rdata = rd_delay == 0 ? rd_pend : $urandom;
        end else
            nx_rdata = $urandom;
        if (o_dropped) drop_cnt++;
        if (tx_start) begin
            check("tx_start_while_busy", 64'(tx_busy), 64'(0));
            if (got.size() == 0) first_start_cyc = cyc;
            got.push_back(tx_byte);
            if (hold_busy) begin
                busy_wait = 0;
                busy_len = 12;
            end else if ($urandom_range(0, 5) == 0) begin
                busy_wait = 0;
                busy_len = 0;
            end else begin
                busy_wait = $urandom_range(0, 2);
                busy_len = $urandom_range(1, 4);
            end
        end
        if (busy_wait > 0) begin
            busy_wait--;
            nx_busy = 1'b0;
        end else if (busy_len > 0) begin
            busy_len--;
            nx_busy = 1'b1;
        end else
            nx_busy = 1'b0;
    end

    task automatic wait_tx_idle();
        bit ok = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clock);
            if (!tx_busy) begin
                ok = 1;
                break;
            end
        end
        check("tx_idle_wait", 64'(ok), 64'(1));
    endtask

    task automatic run_txn(input logic [7:0] cmd, input logic rw, input logic [14:0] addr,
                           input logic [31:0] data, input logic [2:0] err, input bit noise, input int drop_at);
        logic [7:0] exp[$];
        logic [31:0] word;
        int exp_lat, n_drops, t0;
        bit timeout;
        exp = {};
`ifdef CMD_ECHO_EN
        exp.push_back(cmd);
`endif
        if (err != 0)
            exp.push_back(8'hE0 | {5'b0, err});
        else if (!rw) begin
            exp.push_back(8'hAA);
            ref_mem[int'(addr)] = data;
        end else begin
            word = ref_mem.exists(int'(addr)) ? ref_mem[int'(addr)] : 32'h0;
            for (int i = 0; i < 4; i++) exp.push_back(word[8*i +: 8]);
        end
        exp_lat = err != 0 ? -1 : rw ? 2 + LAT : 2;
        wait_tx_idle();
        @(posedge clock);
        #1;
        got = {};
        en_cnt = 0;
        we_cnt = 0;
        drop_cnt = 0;
        n_drops = 0;
        first_start_cyc = -1000;
        i_done = 1'b1;
        i_command = cmd;
        i_readwrite = rw;
        i_address = addr;
        i_data = data;
        i_error = err;
        t0 = cyc;
        @(posedge clock);
        #1;
        i_done = 1'b0;
        timeout = 1;
        for (int k = 0; k < 3000; k++) begin
            if (!o_busy) begin
                timeout = 0;
                break;
            end
            if ((noise && $urandom_range(0, 7) == 0) || k == drop_at) begin
                i_done = 1'b1;
                i_readwrite = 1'($urandom);
                i_command = 8'($urandom);
                i_address = 15'($urandom);
                i_data = $urandom;
                i_error = 3'($urandom);
                n_drops++;
            end
            @(posedge clock);
            #1;
            i_done = 1'b0;
        end
        repeat (2) @(posedge clock);
        #1;
        check("busy_falls", 64'(timeout), 64'(0));
        check("byte_count", 64'(got.size()), 64'(exp.size()));
        for (int i = 0; i < exp.size(); i++)
            check($sformatf("byte%0d", i), i < got.size() ? 64'(got[i]) : 64'hFFFF, 64'(exp[i]));
        check("mem_en_pulses", 64'(en_cnt), 64'(err != 0 ? 0 : 1));
        check("mem_we_pulses", 64'(we_cnt), 64'((err == 0 && !rw) ? 1 : 0));
        if (err == 0 && !rw) begin
            check("mem_waddr", 64'(last_waddr), 64'(addr));
            check("mem_wdata", 64'(last_wdata), 64'(data));
        end
        check("dropped", 64'(drop_cnt), 64'(n_drops));
        if (exp_lat > 0) check("first_tx_latency", 64'(first_start_cyc - t0), 64'(exp_lat));
    endtask

    initial begin
        logic [14:0] pool[8];
        logic [2:0] e;
        logic r;
        logic [7:0] c;
        bit ok;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        check("rst_tx_start", 64'(tx_start), 64'(0));
        check("rst_mem_en", 64'(mem_en), 64'(0));
        check("rst_mem_we", 64'(mem_we), 64'(0));
        check("rst_busy", 64'(o_busy), 64'(0));
        check("rst_tx_byte", 64'(tx_byte), 64'(0));
        check("rst_dropped", 64'(o_dropped), 64'(0));
        run_txn(8'h02, 1'b0, 15'h1234, 32'hDEADBEEF, 3'b000, 0, -1);
        run_txn(8'h01, 1'b1, 15'h1234, 32'h0, 3'b000, 0, -1);
        run_txn(8'h01, 1'b1, 15'h1234, 32'h0, 3'b010, 0, -1);
        run_txn(8'h01, 1'b1, 15'h1234, 32'h0, 3'b000, 0, 5 + LAT);
        run_txn(8'h02, 1'b0, 15'h0000, 32'h01020304, 3'b000, 0, -1);
        run_txn(8'h01, 1'b1, 15'h0000, 32'h0, 3'b000, 0, -1);
        run_txn(8'h02, 1'b0, 15'h7FFF, 32'hA5A5_0F0F, 3'b000, 0, -1);
        run_txn(8'h01, 1'b1, 15'h7FFF, 32'h0, 3'b000, 0, -1);
        // Reset while the second read byte waits for the transmitter to drop busy.
        wait_tx_idle();
        hold_busy = 1;
        @(posedge clock);
        #1;
        got = {};
        i_done = 1'b1;
        i_readwrite = 1'b1;
        i_command = 8'h01;
        i_address = 15'h1234;
        i_error = 3'b000;
        @(posedge clock);
        #1;
        i_done = 1'b0;
        ok = 0;
        for (int k = 0; k < 500; k++) begin
            @(negedge clock);
            #1;
            if (got.size() == 2 && tx_busy) begin
                ok = 1;
                break;
            end
        end
        check("reach_second_byte", 64'(ok), 64'(1));
        @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #2;
        reset = 1'b0;
        check("abort_tx_start", 64'(tx_start), 64'(0));
        check("abort_mem_en", 64'(mem_en), 64'(0));
        check("abort_mem_we", 64'(mem_we), 64'(0));
        check("abort_busy", 64'(o_busy), 64'(0));
        check("abort_tx_byte", 64'(tx_byte), 64'(0));
        check("abort_mem_addr", 64'(mem_addr), 64'(0));
        hold_busy = 0;
        run_txn(8'h02, 1'b0, 15'h0042, 32'h1357_9BDF, 3'b000, 0, -1);
        run_txn(8'h01, 1'b1, 15'h0042, 32'h0, 3'b000, 0, -1);
        pool[0] = 15'h0000;
        pool[1] = 15'h7FFF;
        for (int i = 2; i < 8; i++) pool[i] = 15'($urandom);
        for (int n = 0; n < 40; n++) begin
            e = $urandom_range(0, 4) == 0 ? 3'($urandom_range(1, 7)) : 3'b000;
            r = 1'($urandom);
            c = $urandom_range(0, 3) == 0 ? 8'($urandom) : (r ? 8'h01 : 8'h02);
            run_txn(c, r, pool[$urandom_range(0, 7)], $urandom, e, 1, -1);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/command_executor.md
Name: command_executor

Overview:
- Downstream stage of the UART command decoder; consumes its decoded packet (command, 15-bit address, 32-bit data, error, done pulse).
- Executes the packet against a single-port synchronous RAM.
- Returns a response over a byte-wide handshake to the UART transmitter.
  - Write: one ACK byte.
  - Read: 4 data bytes, LSB first.
  - Decoder error: one error byte.

Parameters:
- ADDR_W, 15, RAM address width.
- DATA_W, 32, RAM word width; fixed at 4 bytes.
- MEM_LATENCY, 1, cycles from mem_en (read) to valid mem_rdata; legal range 1..4.
- ACK_BYTE, 8'hAA, response byte for a successful write.
- ERR_PREFIX, 8'hE0, OR-ed with the 3-bit error code to form the error response.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- i_done  in  1  one-cycle packet-valid pulse from the decoder
- i_readwrite  in  1  1 = read, 0 = write
- i_command  in  8  raw command byte
- i_address  in  ADDR_W  word address
- i_data  in  DATA_W  write data
- i_error  in  3  decoder error code; 0 = none
- mem_en  out  1  RAM enable
- mem_we  out  1  RAM write enable
- mem_addr  out  ADDR_W  RAM address
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM read data
- tx_byte  out  8  byte to transmit
- tx_start  out  1  one-cycle transmit request
- tx_busy  in  1  transmitter busy
- o_busy  out  1  executor not in IDLE
- o_dropped  out  1  one-cycle pulse: packet arrived while busy

Behaviour:
- Reset (synchronous, active-high): all outputs 0; state IDLE; internal byte counter 0. Reset mid-operation aborts immediately: tx_start, mem_en and mem_we all read 0 on the cycle after reset is sampled.
- IDLE, on i_done = 1: latch all i_* fields.
  - i_error != 0 -> RESP with one byte, ERR_PREFIX | {5'b0, i_error}.
  - i_readwrite = 0 -> MEM_WR.
  - otherwise -> MEM_RD.
- MEM_WR: mem_en = mem_we = 1 for exactly one cycle with the latched address and data; then RESP with one byte, ACK_BYTE.
- MEM_RD: mem_en = 1, mem_we = 0 for one cycle. Then RD_WAIT counts MEM_LATENCY cycles and captures mem_rdata into a 32-bit shift register. Then RESP with 4 bytes.
- RESP/TX_REQ: wait for tx_busy = 0, then drive tx_byte and pulse tx_start for one cycle. tx_byte stays stable until the next load.
- TX_ACK: wait for tx_busy = 1. If tx_busy stays low for 16 cycles, treat the byte as accepted (covers transmitters with an immediate busy drop).
- TX_DONE: wait for tx_busy = 0.
  - Decrement the remaining-byte count; shift data right by 8.
  - Count > 0 -> TX_REQ; count = 0 -> IDLE.
- Byte order: a read sends data[7:0], [15:8], [23:16], [31:24], matching the decoder's write-data byte order.
- i_done while o_busy = 1: the packet is ignored and o_dropped pulses for one cycle; the in-flight operation is unaffected. i_done on the same cycle the FSM returns to IDLE is also dropped (IDLE must be registered first).
- Address is used unmodified; no wrap or bounds check. The RAM depth is 2^ADDR_W.
- Minimum latency, i_done to first tx_start:
  - write: 2 cycles;
  - read: 2 + MEM_LATENCY cycles.

Optional Feature:
- CMD_ECHO_EN defined: every response is prefixed with the latched i_command byte.
  - Writes and errors send 2 bytes; reads send 5.
  - The echo is sent first, the byte count is incremented by one, and the handshake is the same.
- Undefined: no echo; byte counts are 1 / 1 / 4.

Decomposition:
- Shared package cmd_pkg:
  - command codes CMD_READ = 8'h01, CMD_WRITE = 8'h02;
  - error codes ERR_NONE/ERR_CMD/ERR_ADDR0/ERR_ADDR1/ERR_DATA (3'b000..3'b1xx);
  - ACK_BYTE and ERR_PREFIX defaults;
  - executor state encoding.
- One natural sub-module, resp_serializer: holds the shift register and byte counter, and runs the tx_start/tx_busy handshake. The executor FSM only loads it and waits for its done.

Test Plan:
- Write 0x02, addr 0x1234, data 0xDEADBEEF, no error -> one mem_we pulse with addr 0x1234 and wdata 0xDEADBEEF; tx sends 0xAA; o_busy falls afterwards.
- Read 0x01, addr 0x1234 after the write above (MEM_LATENCY = 1 and 3) -> tx bytes 0xEF, 0xBE, 0xAD, 0xDE in order; exactly 4 tx_start pulses, each only while tx_busy = 0.
- i_error = 3'b010 -> no mem_en; tx sends 0xE2.
- Second i_done 5 cycles into a read response -> o_dropped pulses once; the read still returns 4 correct bytes.
- Reset asserted while the 2nd read byte is in TX_DONE -> next cycle all outputs 0 and state IDLE; a fresh write afterwards completes normally.
- CMD_ECHO_EN defined, read of 0x0000 holding 0x01020304 -> tx bytes 0x01, 0x04, 0x03, 0x02, 0x01.
